// File: rtl/mips_pkg.sv
// Shared MIPS definitions: R-type funct codes for the HI/LO class, the
// multiply/divide FSM state type and the datapath width.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate: yields the magnitude of a negative
// operand on entry, and re-applies a sign to results in the FIX state.
module muldiv_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] mag
);

  assign mag = neg ? -val : val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO; stalls the front end
// while busy. Define MULDIV_EARLY_TERM_EN to end multiplies once no multiplier bits remain.
module ex_muldiv_unit #(
  parameter int XLEN  = mips_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic            flush,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            div0,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  import mips_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  muldiv_state_t     state, state_nx;
  logic [2*XLEN-1:0] acc;   // product, or {remainder, dividend/quotient}
  logic [2*XLEN-1:0] opa;   // shifting multiplicand, or divisor in low half
  logic [XLEN-1:0]   opb;   // multiplier bits still to consume
  logic [CNT_W-1:0]  cnt;
  logic              is_mul, neg_a, neg_b;

  logic class_op, is_mul_op, is_div_op, signed_op, accept, mul_done;
  logic rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag, quo_fix, rem_fix;
  logic [2*XLEN-1:0] prod_fix, mul_acc, div_acc;
  logic [XLEN:0]     div_diff;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    class_op  = 1'b0;
    is_mul_op = 1'b0;
    is_div_op = 1'b0;
    signed_op = 1'b0;
    case (funct)
      FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO: class_op = 1'b1;
      FUNCT_MULT:  begin class_op = 1'b1; is_mul_op = 1'b1; signed_op = 1'b1; end
      FUNCT_MULTU: begin class_op = 1'b1; is_mul_op = 1'b1; end
      FUNCT_DIV:   begin class_op = 1'b1; is_div_op = 1'b1; signed_op = 1'b1; end
      FUNCT_DIVU:  begin class_op = 1'b1; is_div_op = 1'b1; end
      default: ;
    endcase
  end

  assign busy   = (state != IDLE);
  assign stall  = op_valid & ~flush & class_op & busy;
  assign accept = op_valid & ~flush & class_op & (state == IDLE);

  always_comb begin
    result = '0;
    if (funct == FUNCT_MFHI)      result = hi;
    else if (funct == FUNCT_MFLO) result = lo;
  end

  assign rs_neg = signed_op & rs_val[XLEN-1];
  assign rt_neg = signed_op & rt_val[XLEN-1];

  muldiv_abs #(.W(XLEN))   u_abs_rs  (.val(rs_val),           .neg(rs_neg), .mag(rs_mag));
  muldiv_abs #(.W(XLEN))   u_abs_rt  (.val(rt_val),           .neg(rt_neg), .mag(rt_mag));
  muldiv_abs #(.W(2*XLEN)) u_abs_prd (.val(acc),              .neg(neg_a),  .mag(prod_fix));
  muldiv_abs #(.W(XLEN))   u_abs_quo (.val(acc[XLEN-1:0]),    .neg(neg_a),  .mag(quo_fix));
  muldiv_abs #(.W(XLEN))   u_abs_rem (.val(acc[2*XLEN-1:XLEN]), .neg(neg_b), .mag(rem_fix));

  // Restoring divide: the shifted partial remainder needs XLEN+1 bits, and the
  // borrow out of the subtract decides the quotient bit.
  assign mul_acc  = acc + (opb[0] ? opa : '0);
  assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opa[XLEN-1:0]};
  assign div_acc  = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
    mul_done = (cnt == CNT_LAST) || (opb[XLEN-1:1] == '0);
`else
    mul_done = (cnt == CNT_LAST);
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept && is_mul_op)      state_nx = MUL;
        else if (accept && is_div_op) state_nx = (rt_val == '0) ? FIX : DIV;
      end
      MUL:     if (mul_done) state_nx = FIX;
      DIV:     if (cnt == CNT_LAST) state_nx = FIX;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; datapath registers
  // are reset as well so a post-reset op never sees stale operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      div0   <= 1'b0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      cnt    <= '0;
      is_mul <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          cnt    <= '0;
          is_mul <= is_mul_op;
          if (funct == FUNCT_MTHI) hi <= rs_val;
          if (funct == FUNCT_MTLO) lo <= rs_val;
          if (is_mul_op) begin
            div0  <= 1'b0;
            acc   <= '0;
            opa   <= {{XLEN{1'b0}}, rs_mag};
            opb   <= rt_mag;
            neg_a <= rs_neg ^ rt_neg;
            neg_b <= 1'b0;
          end else if (is_div_op) begin
            div0 <= (rt_val == '0);
            opa  <= {{XLEN{1'b0}}, rt_mag};
            if (rt_val == '0) begin
              // Divide by zero: FIX passes these raw values straight to hi/lo.
              acc   <= {rs_val, {XLEN{1'b1}}};
              neg_a <= 1'b0;
              neg_b <= 1'b0;
            end else begin
              acc   <= {{XLEN{1'b0}}, rs_mag};
              neg_a <= rs_neg ^ rt_neg;
              neg_b <= rs_neg;
            end
          end
        end
        MUL: begin
          acc <= mul_acc;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= div_acc;
          cnt <= cnt + 1'b1;
        end
        default: begin
          if (is_mul) begin
            hi <= prod_fix[2*XLEN-1:XLEN];
            lo <= prod_fix[XLEN-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
      endcase
    end
  end

endmodule
